run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// ============================================================================
// run_controller
// ----------------------------------------------------------------------------
// Sequences one run of a small program interpreter. A run starts on a rising
// edge of `run`. The controller then streams input-channel words from the host
// into the interpreter's input memory. It pulses `step` once per instruction
// until the interpreter reports `halted`. Finally it latches the self-check
// result and reports the run status.
//
// States: IDLE -> LOAD -> EXEC -> CHECK -> DONE. A new run edge in DONE
// restarts the sequence.
//
// Parameters
//   MemoryElementWidth  width of one input-channel word
//   NIn                 input-channel capacity in words (>= 1)
//   MaxSteps            step budget, used only when the step limit is built in
//
// Ports
//   clock        single clock; all state changes on its rising edge
//   reset        asynchronous, active-low reset
//   run          start request, acts on its sampled 0->1 transition
//   load_valid   host offers an input-channel word
//   load_data    offered word
//   load_last    offered word is the final one
//   load_ready   controller accepts the offered word (LOAD only)
//   in_we        input-channel write strobe (same cycle as the transfer)
//   in_addr      input-channel write address (= words loaded so far)
//   in_data      input-channel write data (0 when not writing)
//   in_count     words loaded this run
//   step         one-cycle pulse: interpreter executes one instruction
//   halted       interpreter ip has left the program
//   pass         interpreter self-check result, valid while halted=1
//   steps        step pulses issued this run (saturating)
//   finished     run complete
//   success      run complete and self-check passed
//   timeout      run stopped by the step limit
//
// Build option
//   RUN_CONTROLLER_STEP_LIMIT_EN  When defined, EXEC stops after MaxSteps
//   pulses and the run ends with timeout=1. When undefined, EXEC runs until
//   halted, and timeout is always 0.
// ============================================================================
module run_controller #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 3,
    parameter int MaxSteps           = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          load_valid,
    input  logic [MemoryElementWidth-1:0] load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          in_we,
    output logic [$clog2(NIn+1)-1:0]      in_addr,
    output logic [MemoryElementWidth-1:0] in_data,
    output logic [$clog2(NIn+1)-1:0]      in_count,
    output logic                          step,
    input  logic                          halted,
    input  logic                          pass,
    output logic [31:0]                   steps,
    output logic                          finished,
    output logic                          success,
    output logic                          timeout
);

    localparam int CountWidth = $clog2(NIn + 1);
    localparam logic [CountWidth-1:0] NInCount = CountWidth'(NIn);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        CHECK,
        DONE
    } StateT;

    StateT                 r_state;
    StateT                 w_nextState;
    logic                  r_runPrev;
    logic [CountWidth-1:0] r_inCount;
    logic [31:0]           r_steps;
    logic                  r_finished;
    logic                  r_success;
    logic                  r_timeout;

    logic                  w_runEdge;
    logic                  w_loadSpace;
    logic                  w_transfer;
    logic                  w_lastSlot;
    logic                  w_stepLimitHit;

    // A start request is a sampled low-to-high change of run. r_runPrev
    // resets to 1, so a run held high through reset release does not count
    // as an edge. The host must drop run and raise it again.
    assign w_runEdge   = run && !r_runPrev;

    // The channel has room while fewer than NIn words have been written. A
    // transfer needs a valid word, room, and the LOAD state.
    assign w_loadSpace = (r_inCount < NInCount);
    assign w_transfer  = (r_state == LOAD) && load_valid && w_loadSpace;
    assign w_lastSlot  = ((r_inCount + CountWidth'(1)) == NInCount);

    assign in_addr     = r_inCount;
    assign in_data     = in_we ? load_data : '0;
    assign in_count    = r_inCount;
    assign steps       = r_steps;
    assign finished    = r_finished;
    assign success     = r_success;
    assign timeout     = r_timeout;

    // Next-state and strobe decode. Every strobe defaults to 0, so load_ready,
    // in_we and step can only be high in the state that owns them. In EXEC,
    // halted takes priority over the step limit: a program that halts on the
    // same cycle the budget runs out is still judged on its own pass result.
    always_comb begin
        w_nextState    = r_state;
        load_ready     = 1'b0;
        in_we          = 1'b0;
        step           = 1'b0;
        w_stepLimitHit = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_runEdge) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                load_ready = w_loadSpace;
                in_we      = w_transfer;
                if (w_transfer && (load_last || w_lastSlot)) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                if (halted) begin
                    w_nextState = CHECK;
                end else begin
`ifdef RUN_CONTROLLER_STEP_LIMIT_EN
                    if (r_steps == 32'(MaxSteps)) begin
                        w_stepLimitHit = 1'b1;
                        w_nextState    = DONE;
                    end else begin
                        step = 1'b1;
                    end
`else
                    step = 1'b1;
`endif
                end
            end
            CHECK: begin
                w_nextState = DONE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register and run bookkeeping. Reset takes effect at once, from
    // any state. A run edge in IDLE/DONE clears everything for the new run.
    // CHECK lasts exactly one cycle. The pass result is latched on the edge
    // that leaves CHECK. So finished/success appear two edges after halted is
    // first seen in EXEC: one edge into CHECK, one edge out of it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_runPrev  <= 1'b1;
            r_inCount  <= '0;
            r_steps    <= '0;
            r_finished <= 1'b0;
            r_success  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_runPrev <= run;
            case (r_state)
                IDLE, DONE: begin
                    if (w_runEdge) begin
                        r_inCount  <= '0;
                        r_steps    <= '0;
                        r_finished <= 1'b0;
                        r_success  <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_transfer) begin
                        r_inCount <= r_inCount + CountWidth'(1);
                    end
                end
                EXEC: begin
                    if (step && (r_steps != '1)) begin
                        r_steps <= r_steps + 32'd1;
                    end
                    if (w_stepLimitHit) begin
                        r_finished <= 1'b1;
                        r_success  <= 1'b0;
                        r_timeout  <= 1'b1;
                    end
                end
                CHECK: begin
                    r_finished <= 1'b1;
                    r_success  <= pass;
                    r_timeout  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
